// File: rtl/vec_stream_reader.sv
// vec_stream_reader: on-chip vector RAM that streams a contiguous address
// range over valid/ready for a programmable number of passes. The port
// `reset` is asynchronous and active-low.
module vec_stream_reader #(
   parameter int WIDTH  = 64,
   parameter int AWIDTH = 10,
   parameter int DEPTH  = 1024,
   parameter int PASS_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              start,
   input  logic [AWIDTH-1:0] start_addr,
   input  logic [AWIDTH-1:0] end_addr,
   input  logic [PASS_W-1:0] num_passes,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [PASS_W-1:0] out_pass,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);
   localparam int ENTRY_W = WIDTH + 1 + PASS_W;

   state_t              state, state_n;
   logic [AWIDTH-1:0]   rd_addr, rd_addr_n;
   logic [AWIDTH-1:0]   start_q, start_q_n;
   logic [AWIDTH-1:0]   end_q, end_q_n;
   logic [PASS_W-1:0]   pass, pass_n;
   logic [PASS_W-1:0]   num_q, num_q_n;
   logic                done_n, err_n;
   logic                issue;
   logic                bad_cmd;

   logic [WIDTH-1:0]    mem [0:DEPTH-1];
   logic [WIDTH-1:0]    rd_data;
   logic                rd_valid;
   logic                rd_last;
   logic [PASS_W-1:0]   rd_pass;
   logic [ENTRY_W-1:0]  rd_entry;

   logic [ENTRY_W-1:0]  buf0, buf1;
   logic [1:0]          count;
   logic                pop;
   logic [2:0]          occ_after_pop;

   assign bad_cmd  = (end_addr < start_addr) || ({1'b0, end_addr} >= DEPTH_L) ||
                     (num_passes == '0);
   assign pop      = out_valid && out_ready;
   assign occ_after_pop = {1'b0, count} + {2'b00, rd_valid} - {2'b00, pop};
   assign rd_entry = {rd_data, rd_last, rd_pass};

   assign out_valid = (count != 2'd0);
   assign out_data  = buf0[ENTRY_W-1 -: WIDTH];
   assign out_last  = buf0[PASS_W];
   assign out_pass  = buf0[PASS_W-1:0];
   assign busy      = (state != IDLE);

   // Host write port; RAM is never reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Synchronous read; a same-cycle write to this address is seen next time.
   always_ff @(posedge clk) begin
      if (issue) begin
         rd_data <= mem[rd_addr];
      end
   end

   // Tag that travels with each read so the buffer knows last/pass per word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_pass  <= '0;
      end else begin
         rd_valid <= issue;
         if (issue) begin
            rd_last <= (rd_addr == end_q);
            rd_pass <= pass;
         end
      end
   end

   // Two-entry output buffer; buf0 is always the head presented downstream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf0  <= '0;
         buf1  <= '0;
         count <= 2'd0;
      end else begin
         case ({rd_valid, pop})
            2'b10: begin
               if (count == 2'd0) buf0 <= rd_entry;
               else               buf1 <= rd_entry;
               count <= count + 2'd1;
            end
            2'b01: begin
               buf0  <= buf1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  buf0 <= rd_entry;
               end else begin
                  buf0 <= buf1;
                  buf1 <= rd_entry;
               end
            end
            default: ;
         endcase
      end
   end

   // Command FSM: validate, walk the range pass by pass, then wait for drain.
   always_comb begin
      state_n   = state;
      rd_addr_n = rd_addr;
      pass_n    = pass;
      start_q_n = start_q;
      end_q_n   = end_q;
      num_q_n   = num_q;
      done_n    = 1'b0;
      err_n     = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_q_n = start_addr;
               end_q_n   = end_addr;
               num_q_n   = num_passes;
               if (bad_cmd) begin
                  err_n  = 1'b1;
                  done_n = 1'b1;
               end else begin
                  state_n   = RUN;
                  rd_addr_n = start_addr;
                  pass_n    = '0;
               end
            end
         end
         RUN: begin
            if (occ_after_pop < 3'd2) begin
               issue = 1'b1;
               if (rd_addr == end_q) begin
                  if (pass == num_q - PASS_W'(1)) begin
                     state_n = DRAIN;
                  end else begin
                     rd_addr_n = start_q;
                     pass_n    = pass + PASS_W'(1);
                  end
               end else begin
                  rd_addr_n = rd_addr + AWIDTH'(1);
               end
            end
         end
         DRAIN: begin
            if (occ_after_pop == 3'd0) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // FSM and command registers; done/err are registered one-cycle pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         rd_addr <= '0;
         pass    <= '0;
         start_q <= '0;
         end_q   <= '0;
         num_q   <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         rd_addr <= rd_addr_n;
         pass    <= pass_n;
         start_q <= start_q_n;
         end_q   <= end_q_n;
         num_q   <= num_q_n;
         done    <= done_n;
         err     <= err_n;
      end
   end

endmodule

// File: tb/tb_vec_stream_reader.sv
// tb_vec_stream_reader: directed checks of the vector streamer.
module tb_vec_stream_reader;

   localparam int WIDTH  = 64;
   localparam int AWIDTH = 10;
   localparam int DEPTH  = 1024;
   localparam int PASS_W = 2;
   localparam logic [63:0] NEWVAL = 64'h5555_6666_7777_8888;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [AWIDTH-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              start;
   logic [AWIDTH-1:0] start_addr;
   logic [AWIDTH-1:0] end_addr;
   logic [PASS_W-1:0] num_passes;
   logic [WIDTH-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [PASS_W-1:0] out_pass;
   logic              busy;
   logic              done;
   logic              err;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0]  expData[$];
   logic              expLast[$];
   logic [PASS_W-1:0] expPass[$];

   vec_stream_reader #(
      .WIDTH(WIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH), .PASS_W(PASS_W)
   ) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .start_addr(start_addr), .end_addr(end_addr),
      .num_passes(num_passes),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .out_pass(out_pass),
      .busy(busy), .done(done), .err(err)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   function automatic logic [63:0] wordVal(input int a);
      return 64'hC0DE_0000_0000_00A0 + 64'(a);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic writeWord(input int a, input logic [63:0] d);
      wr_en   = 1'b1;
      wr_addr = a[AWIDTH-1:0];
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic applyStimulus(input int s, input int e, input int p);
      start      = 1'b1;
      start_addr = s[AWIDTH-1:0];
      end_addr   = e[AWIDTH-1:0];
      num_passes = p[PASS_W-1:0];
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic buildExpected(input int s, input int e, input int p);
      expData.delete();
      expLast.delete();
      expPass.delete();
      for (int ps = 0; ps < p; ps++) begin
         for (int a = s; a <= e; a++) begin
            expData.push_back(wordVal(a));
            expLast.push_back(a == e);
            expPass.push_back(ps[PASS_W-1:0]);
         end
      end
   endtask

   // mode 0: ready always 1, mode 1: ready toggles 1,0,..., mode 2: random stalls
   task automatic collectStream(input int mode, input int wrIter, input int startIter,
                                input int expFirst);
      int                idx = 0;
      int                iter = 0;
      int                first = -1;
      int                lastIter = -1;
      int                n = expData.size();
      logic              stall = 1'b0;
      logic [WIDTH-1:0]  hd = '0;
      logic              hl = 1'b0;
      logic [PASS_W-1:0] hp = '0;
      while (idx < n && iter < 300) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (iter % 2 == 0);
            default: out_ready = ($urandom_range(0, 2) != 0);
         endcase
         wr_en = (iter == wrIter);
         if (iter == wrIter) begin
            wr_addr = 3;
            wr_data = NEWVAL;
         end
         start = (iter == startIter);
         if (iter == startIter) begin
            start_addr = 0;
            end_addr   = 1;
            num_passes = 1;
         end
         if (stall) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_data", out_data, hd);
            checkOutput("hold_last", out_last, hl);
            checkOutput("hold_pass", out_pass, hp);
         end
         if (out_valid && first < 0) first = iter;
         if (out_valid && out_ready) begin
            checkOutput($sformatf("data[%0d]", idx), out_data, expData[idx]);
            checkOutput($sformatf("last[%0d]", idx), out_last, expLast[idx]);
            checkOutput($sformatf("pass[%0d]", idx), out_pass, expPass[idx]);
            idx++;
            lastIter = iter;
         end
         checkOutput("no_early_done", done, 0);
         stall = out_valid && !out_ready;
         hd    = out_data;
         hl    = out_last;
         hp    = out_pass;
         @(negedge clk);
         iter++;
      end
      wr_en = 1'b0;
      start = 1'b0;
      checkOutput("stream_complete", idx, n);
      checkOutput("done_pulse", done, 1);
      checkOutput("busy_after_done", busy, 0);
      checkOutput("valid_after_done", out_valid, 0);
      checkOutput("err_after_done", err, 0);
      if (expFirst >= 0) checkOutput("first_latency", first, expFirst);
      if (mode == 0) checkOutput("no_bubble", lastIter - first, n - 1);
      @(negedge clk);
      checkOutput("done_one_cycle", done, 0);
   endtask

   task automatic checkIllegal(input int s, input int e, input int p);
      applyStimulus(s, e, p);
      checkOutput("illegal_err", err, 1);
      checkOutput("illegal_done", done, 1);
      checkOutput("illegal_busy", busy, 0);
      checkOutput("illegal_valid", out_valid, 0);
      @(negedge clk);
      checkOutput("illegal_err_clear", err, 0);
      checkOutput("illegal_done_clear", done, 0);
      checkOutput("illegal_valid_later", out_valid, 0);
   endtask

   // Directed test sequence.
   initial begin
      reset      = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      start      = 1'b0;
      start_addr = '0;
      end_addr   = '0;
      num_passes = '0;
      out_ready  = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_data", out_data, 0);
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_last", out_last, 0);
      checkOutput("rst_pass", out_pass, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      reset = 1'b1;
      @(negedge clk);

      for (int a = 0; a < 8; a++) writeWord(a, wordVal(a));

      $display("[TB] single pass 0..3");
      buildExpected(0, 3, 1);
      applyStimulus(0, 3, 1);
      checkOutput("busy_after_start", busy, 1);
      collectStream(0, -1, -1, 2);

      $display("[TB] three passes 2..4");
      buildExpected(2, 4, 3);
      applyStimulus(2, 4, 3);
      collectStream(0, -1, -1, 2);

      $display("[TB] three passes 2..4, toggling ready");
      applyStimulus(2, 4, 3);
      collectStream(1, -1, -1, 2);

      $display("[TB] three passes 2..4, random stalls");
      applyStimulus(2, 4, 3);
      collectStream(2, -1, -1, -1);

      $display("[TB] single word range, two passes");
      buildExpected(5, 5, 2);
      applyStimulus(5, 5, 2);
      collectStream(0, -1, -1, 2);

      $display("[TB] illegal commands");
      checkIllegal(7, 3, 1);
      checkIllegal(0, 3, 0);

      $display("[TB] write during read of addr3");
      buildExpected(0, 3, 2);
      expData[7] = NEWVAL;
      applyStimulus(0, 3, 2);
      collectStream(0, 3, -1, 2);
      writeWord(3, wordVal(3));

      $display("[TB] reset mid-stream");
      out_ready = 1'b1;
      applyStimulus(0, 3, 3);
      repeat (4) @(negedge clk);
      checkOutput("pre_reset_valid", out_valid, 1);
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_data", out_data, 0);
      checkOutput("mid_rst_valid", out_valid, 0);
      checkOutput("mid_rst_last", out_last, 0);
      checkOutput("mid_rst_pass", out_pass, 0);
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_done", done, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("post_rst_done", done, 0);
         checkOutput("post_rst_busy", busy, 0);
         checkOutput("post_rst_valid", out_valid, 0);
      end

      $display("[TB] restart after reset with start pulsed while busy");
      buildExpected(1, 4, 2);
      applyStimulus(1, 4, 2);
      collectStream(0, -1, 4, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit so the bench always terminates.
   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
